// File: rtl/rx_byte_assembler_pkg.sv
// ---------------------------------------------------------------------------
// rx_byte_assembler_pkg
// Shared definitions for the receive byte assembler: byte and counter widths,
// the bit-stuffing limit, the EOP length, the K line level that the sync
// pattern ends on, and the state encoding of the assembler FSM.
// No ports (package).
// ---------------------------------------------------------------------------
package rx_byte_assembler_pkg;

  localparam int DATA_W      = 8;
  localparam int STUFF_LIMIT = 6;
  localparam int EOP_BITS    = 2;
  localparam int CNT_W       = 10;

  localparam int BIT_CNT_W  = $clog2(DATA_W);
  localparam int ONES_CNT_W = $clog2(STUFF_LIMIT + 1);
  localparam int EOP_CNT_W  = $clog2(EOP_BITS + 1);

  // Index of the final data bit of a byte, and the SE0 count one short of EOP
  localparam logic [BIT_CNT_W-1:0]  LAST_BIT_IDX = BIT_CNT_W'(DATA_W - 1);
  localparam logic [ONES_CNT_W-1:0] ONES_LIMIT   = ONES_CNT_W'(STUFF_LIMIT);
  localparam logic [EOP_CNT_W-1:0]  EOP_LAST     = EOP_CNT_W'(EOP_BITS - 1);

  // Line level for K; J is its complement
  localparam logic LINE_K = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RECV,
    ST_EOP_WAIT,
    ST_DONE
  } rxState_t;

endpackage

// File: rtl/rx_byte_assembler_nrzi_destuff.sv
// ---------------------------------------------------------------------------
// rx_byte_assembler_nrzi_destuff
// NRZI decoder and run-of-ones tracker. A line level equal to the previous
// one decodes as 1, a change decodes as 0. After STUFF_LIMIT consecutive 1s
// the next bit must be a stuffed 0, which is swallowed here; a 1 in that
// position is reported as a stuffing error.
// Ports:
//   i_clk, i_rst_n  clock, asynchronous active-low reset
//   i_load          start of packet: previous level = K, run of ones = 1
//   i_sample        a data bit time is being consumed this cycle
//   i_line          line level (1=J, 0=K)
//   o_bit           decoded bit for the current line level
//   o_bitEn         o_bit is a real data bit (not a stuffed 0, not an error)
//   o_stuffErr      too many consecutive 1s on this bit time
// ---------------------------------------------------------------------------
module rx_byte_assembler_nrzi_destuff
  import rx_byte_assembler_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_load,
  input  logic i_sample,
  input  logic i_line,
  output logic o_bit,
  output logic o_bitEn,
  output logic o_stuffErr
);

  logic                  r_prevLevel;
  logic [ONES_CNT_W-1:0] r_onesCnt;
  logic                  w_decoded;
  logic                  w_atLimit;

  assign w_decoded  = (i_line == r_prevLevel);
  assign w_atLimit  = (r_onesCnt == ONES_LIMIT);

  assign o_bit      = w_decoded;
  assign o_bitEn    = i_sample & ~w_atLimit;
  assign o_stuffErr = i_sample & w_atLimit & w_decoded;

  // The sync pattern ends in K with a decoded 1, so a new packet starts with
  // the previous level at K and one 1 already counted. The run of ones
  // deliberately carries across byte boundaries.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_prevLevel <= 1'b0;
      r_onesCnt   <= '0;
    end else if (i_load) begin
      r_prevLevel <= LINE_K;
      r_onesCnt   <= ONES_CNT_W'(1);
    end else if (i_sample) begin
      r_prevLevel <= i_line;
      if (w_atLimit || !w_decoded) begin
        r_onesCnt <= '0;
      end else begin
        r_onesCnt <= r_onesCnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/rx_byte_assembler.sv
// ---------------------------------------------------------------------------
// rx_byte_assembler
// Receive datapath stage: while the receiver is in its data state, turns
// NRZI line samples into LSB-first bytes with stuffed bits removed, and
// reports end-of-packet and stuffing/alignment errors.
// Ports:
//   i_clk, i_rst_n    clock, asynchronous active-low reset
//   i_rxEnable        receiver state machine is in its data state
//   i_bitValid        one-cycle strobe per bit time; line sampled only then
//   i_lineIn          differential line level (1=J, 0=K)
//   i_se0             single-ended zero on the line
//   o_rxData          last completed byte, held until the next completion
//   o_rxValid         pulse: o_rxData updated this cycle
//   o_rxEop           pulse: EOP recognised
//   o_rxStuffErr      pulse: stuffing violation, or SE0 too short for EOP
//   o_rxAlignErr      pulse alongside o_rxEop when a partial byte is pending
//   o_byteCount       bytes completed in this packet, saturating
// ---------------------------------------------------------------------------
module rx_byte_assembler
  import rx_byte_assembler_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_rxEnable,
  input  logic              i_bitValid,
  input  logic              i_lineIn,
  input  logic              i_se0,
  output logic [DATA_W-1:0] o_rxData,
  output logic              o_rxValid,
  output logic              o_rxEop,
  output logic              o_rxStuffErr,
  output logic              o_rxAlignErr,
  output logic [CNT_W-1:0]  o_byteCount
);

  rxState_t              r_state;
  rxState_t              w_nextState;

  logic [DATA_W-2:0]     r_shift;
  logic [BIT_CNT_W-1:0]  r_bitCnt;
  logic [EOP_CNT_W-1:0]  r_eopCnt;
  logic [DATA_W-1:0]     r_rxData;
  logic [CNT_W-1:0]      r_byteCount;
  logic                  r_rxValid;
  logic                  r_rxEop;
  logic                  r_rxStuffErr;
  logic                  r_rxAlignErr;

  logic                  w_load;
  logic                  w_sample;
  logic                  w_bit;
  logic                  w_bitEn;
  logic                  w_stuffErr;
  logic                  w_eopStart;
  logic                  w_eopStep;
  logic                  w_eopHit;
  logic                  w_lineErr;

  // Only the previous DATA_W-1 bits need storing: the final bit of a byte
  // goes straight from the decoder into the completed byte.
  assign w_load   = i_rxEnable & i_bitValid & (r_state == ST_IDLE);
  assign w_sample = i_rxEnable & i_bitValid & (r_state == ST_RECV) & ~i_se0;

  rx_byte_assembler_nrzi_destuff u_destuff (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_load     (w_load),
    .i_sample   (w_sample),
    .i_line     (i_lineIn),
    .o_bit      (w_bit),
    .o_bitEn    (w_bitEn),
    .o_stuffErr (w_stuffErr)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Dropping i_rxEnable aborts from any state on any edge; everything else
  // moves only on bit strobes. SE0 takes priority over the line level.
  always_comb begin
    w_nextState = r_state;
    w_eopStart  = 1'b0;
    w_eopStep   = 1'b0;
    w_eopHit    = 1'b0;
    w_lineErr   = 1'b0;
    if (!i_rxEnable) begin
      w_nextState = ST_IDLE;
    end else if (i_bitValid) begin
      unique case (r_state)
        ST_IDLE: begin
          w_nextState = ST_RECV;
        end
        ST_RECV: begin
          if (i_se0) begin
            w_nextState = ST_EOP_WAIT;
            w_eopStart  = 1'b1;
          end else if (w_stuffErr) begin
            w_nextState = ST_DONE;
          end
        end
        ST_EOP_WAIT: begin
          if (!i_se0) begin
            w_lineErr   = 1'b1;
            w_nextState = ST_DONE;
          end else if (r_eopCnt == EOP_LAST) begin
            w_eopHit    = 1'b1;
            w_nextState = ST_DONE;
          end else begin
            w_eopStep   = 1'b1;
          end
        end
        ST_DONE: begin
          w_nextState = ST_DONE;
        end
        default: begin
          w_nextState = ST_IDLE;
        end
      endcase
    end
  end

  // Shifter, counters and the one-cycle status pulses. The byte completes
  // on the same edge that samples its final bit.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_shift      <= '0;
      r_bitCnt     <= '0;
      r_eopCnt     <= '0;
      r_rxData     <= '0;
      r_byteCount  <= '0;
      r_rxValid    <= 1'b0;
      r_rxEop      <= 1'b0;
      r_rxStuffErr <= 1'b0;
      r_rxAlignErr <= 1'b0;
    end else begin
      r_rxValid    <= 1'b0;
      r_rxEop      <= 1'b0;
      r_rxStuffErr <= 1'b0;
      r_rxAlignErr <= 1'b0;

      if (w_load) begin
        r_shift     <= '0;
        r_bitCnt    <= '0;
        r_byteCount <= '0;
      end

      if (w_bitEn) begin
        r_shift <= {w_bit, r_shift[DATA_W-2:1]};
        if (r_bitCnt == LAST_BIT_IDX) begin
          r_bitCnt  <= '0;
          r_rxData  <= {w_bit, r_shift};
          r_rxValid <= 1'b1;
          if (r_byteCount != '1) begin
            r_byteCount <= r_byteCount + 1'b1;
          end
        end else begin
          r_bitCnt <= r_bitCnt + 1'b1;
        end
      end

      if (w_stuffErr || w_lineErr) begin
        r_rxStuffErr <= 1'b1;
      end

      if (w_eopStart) begin
        r_eopCnt <= EOP_CNT_W'(1);
      end else if (w_eopStep) begin
        r_eopCnt <= r_eopCnt + 1'b1;
      end

      if (w_eopHit) begin
        r_rxEop      <= 1'b1;
        r_rxAlignErr <= (r_bitCnt != '0);
      end
    end
  end

  assign o_rxData     = r_rxData;
  assign o_rxValid    = r_rxValid;
  assign o_rxEop      = r_rxEop;
  assign o_rxStuffErr = r_rxStuffErr;
  assign o_rxAlignErr = r_rxAlignErr;
  assign o_byteCount  = r_byteCount;

endmodule

// File: tb/tb_rx_byte_assembler.sv
// ---------------------------------------------------------------------------
// tb_rx_byte_assembler
// Builds packets from byte values (LSB-first bits, bit stuffing, NRZI), plays
// them onto the line with random idle cycles between bit strobes, and checks
// every cycle against expectations attached to each line symbol.
// ---------------------------------------------------------------------------
module tb_rx_byte_assembler;
  import rx_byte_assembler_pkg::*;

  typedef struct {
    logic              level;
    logic              se0;
    logic              expValid;
    logic [DATA_W-1:0] expData;
    logic              expEop;
    logic              expAlign;
    logic              expStuff;
  } sym_t;

  logic              clk = 1'b0;
  logic              rstN;
  logic              rxEnable;
  logic              bitValid;
  logic              lineIn;
  logic              se0;
  logic [DATA_W-1:0] rxData;
  logic              rxValid;
  logic              rxEop;
  logic              rxStuffErr;
  logic              rxAlignErr;
  logic [CNT_W-1:0]  byteCount;

  int numChecks = 0;
  int numBad    = 0;

  logic [DATA_W-1:0] modelData;
  logic [CNT_W-1:0]  modelCount;
  logic              encLevel;
  int                encOnes;
  sym_t              symQ[$];
  logic [DATA_W-1:0] byteQ[$];

  always #5 clk = ~clk;

  rx_byte_assembler dut (
    .i_clk        (clk),
    .i_rst_n      (rstN),
    .i_rxEnable   (rxEnable),
    .i_bitValid   (bitValid),
    .i_lineIn     (lineIn),
    .i_se0        (se0),
    .o_rxData     (rxData),
    .o_rxValid    (rxValid),
    .o_rxEop      (rxEop),
    .o_rxStuffErr (rxStuffErr),
    .o_rxAlignErr (rxAlignErr),
    .o_byteCount  (byteCount)
  );

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    numChecks++;
    if (observed !== expected) begin
      numBad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  function automatic sym_t emptySym();
    sym_t s;
    s.level    = LINE_K;
    s.se0      = 1'b0;
    s.expValid = 1'b0;
    s.expData  = '0;
    s.expEop   = 1'b0;
    s.expAlign = 1'b0;
    s.expStuff = 1'b0;
    return s;
  endfunction

  // One clock with the given inputs; returns 1 time unit after the edge
  task automatic tick(input logic bv, input logic lvl, input logic s0);
    bitValid = bv;
    lineIn   = lvl;
    se0      = s0;
    @(posedge clk);
    #1;
    bitValid = 1'b0;
  endtask

  // Compare all outputs against a symbol's expectations and the held byte/count
  task automatic checkSym(input sym_t s);
    if (s.expValid) begin
      modelData = s.expData;
      if (modelCount != '1) modelCount = modelCount + 1'b1;
    end
    checkOutput("valid", rxValid, s.expValid);
    checkOutput("eop", rxEop, s.expEop);
    checkOutput("align", rxAlignErr, s.expAlign);
    checkOutput("stuff", rxStuffErr, s.expStuff);
    checkOutput("data", rxData, modelData);
    checkOutput("count", byteCount, modelCount);
  endtask

  // Append one decoded data bit to the line stream, stuffing a 0 first if due
  task automatic pushBit(input logic d, input logic lastOfByte, input logic [DATA_W-1:0] byteVal);
    sym_t s;
    s = emptySym();
    if (encOnes == STUFF_LIMIT) begin
      encLevel = ~encLevel;
      s.level  = encLevel;
      symQ.push_back(s);
      encOnes  = 0;
    end
    if (!d) encLevel = ~encLevel;
    s.level    = encLevel;
    s.expValid = lastOfByte;
    s.expData  = byteVal;
    symQ.push_back(s);
    encOnes = d ? encOnes + 1 : 0;
  endtask

  // Turn byteQ (plus extra trailing bits and an optional EOP) into symQ
  task automatic buildPacket(input int extraBits, input bit withEop);
    sym_t s;
    symQ.delete();
    encLevel = LINE_K;
    encOnes  = 1;
    foreach (byteQ[i]) begin
      for (int b = 0; b < DATA_W; b++) pushBit(byteQ[i][b], b == DATA_W - 1, byteQ[i]);
    end
    for (int e = 0; e < extraBits; e++) pushBit(1'($urandom_range(0, 1)), 1'b0, '0);
    if (withEop) begin
      s = emptySym();
      s.se0   = 1'b1;
      s.level = 1'($urandom_range(0, 1));
      symQ.push_back(s);
      s.expEop   = 1'b1;
      s.expAlign = ((extraBits % DATA_W) != 0);
      symQ.push_back(s);
    end
  endtask

  // Enable, send the start strobe, then play symQ with random idle gaps
  task automatic applyStimulus(input int maxGap, input bit terminated);
    rxEnable = 1'b1;
    tick(1'b1, LINE_K, 1'b0);
    modelCount = '0;
    checkSym(emptySym());
    foreach (symQ[i]) begin
      repeat ($urandom_range(0, maxGap)) begin
        tick(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        checkSym(emptySym());
      end
      tick(1'b1, symQ[i].level, symQ[i].se0);
      checkSym(symQ[i]);
    end
    if (terminated) begin
      repeat (2) begin
        tick(1'b1, 1'($urandom_range(0, 1)), 1'b0);
        checkSym(emptySym());
      end
    end
  endtask

  // Drop enable; nothing may come out and byte/count must hold
  task automatic endPacket();
    rxEnable = 1'b0;
    tick(1'b0, LINE_K, 1'b0);
    checkSym(emptySym());
    tick(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    checkSym(emptySym());
  endtask

  initial begin
    sym_t s;
    rstN       = 1'b1;
    rxEnable   = 1'b0;
    bitValid   = 1'b0;
    lineIn     = ~LINE_K;
    se0        = 1'b0;
    modelData  = '0;
    modelCount = '0;

    #2 rstN = 1'b0;
    #1;
    checkSym(emptySym());
    @(posedge clk);
    @(posedge clk);
    #1 rstN = 1'b1;
    checkSym(emptySym());

    $display("[TB] single byte 0x00 from alternating J/K");
    byteQ = '{8'h00};
    buildPacket(0, 1'b0);
    applyStimulus(2, 1'b0);
    endPacket();

    $display("[TB] byte 0xFF with a stuffed bit");
    byteQ = '{8'hFF};
    buildPacket(0, 1'b0);
    applyStimulus(2, 1'b0);
    endPacket();

    $display("[TB] seven decoded ones without stuffing");
    symQ.delete();
    s = emptySym();
    repeat (STUFF_LIMIT - 1) symQ.push_back(s);
    s.expStuff = 1'b1;
    symQ.push_back(s);
    applyStimulus(2, 1'b1);
    endPacket();

    $display("[TB] bytes 0xA5 0x3C then EOP");
    byteQ = '{8'hA5, 8'h3C};
    buildPacket(0, 1'b1);
    applyStimulus(2, 1'b1);
    endPacket();

    $display("[TB] byte 0xA5 plus three bits then EOP");
    byteQ = '{8'hA5};
    buildPacket(3, 1'b1);
    applyStimulus(2, 1'b1);
    endPacket();

    $display("[TB] SE0 too short for EOP");
    byteQ = '{8'h5A};
    buildPacket(0, 1'b0);
    s = emptySym();
    s.se0 = 1'b1;
    symQ.push_back(s);
    s.se0 = 1'b0;
    s.expStuff = 1'b1;
    symQ.push_back(s);
    applyStimulus(2, 1'b1);
    endPacket();

    $display("[TB] random packets");
    for (int p = 0; p < 20; p++) begin
      byteQ.delete();
      repeat ($urandom_range(0, 4)) byteQ.push_back(8'($urandom_range(0, 255)));
      buildPacket($urandom_range(0, DATA_W - 1), 1'b1);
      applyStimulus(2, 1'b1);
      endPacket();
    end

    $display("[TB] byte counter saturation");
    byteQ.delete();
    repeat ((1 << CNT_W) + 6) byteQ.push_back(8'($urandom_range(0, 255)));
    buildPacket(0, 1'b1);
    applyStimulus(0, 1'b1);
    endPacket();

    $display("[TB] abort mid-byte, then async reset mid-byte");
    byteQ.delete();
    buildPacket(4, 1'b0);
    applyStimulus(2, 1'b0);
    endPacket();
    buildPacket(4, 1'b0);
    applyStimulus(2, 1'b0);
    #2 rstN = 1'b0;
    #1;
    modelData  = '0;
    modelCount = '0;
    checkSym(emptySym());
    rxEnable = 1'b0;
    tick(1'b1, LINE_K, 1'b0);
    checkSym(emptySym());
    rstN = 1'b1;
    tick(1'b1, ~LINE_K, 1'b0);
    checkSym(emptySym());

    $display("test done: total=%0d bad=%0d", numChecks, numBad);
    $finish;
  end

endmodule
